// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the machine-mode CSR access controller:
//   - addresses of the CSRs this controller is allowed to touch
//   - csr_op_e   : Zicsr funct3 encodings
//   - ctrl_state_e : controller sequencing states
//   - small decode helpers used by the controller
// -----------------------------------------------------------------------------
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    OP_RW  = 3'b001,
    OP_RS  = 3'b010,
    OP_RC  = 3'b011,
    OP_RWI = 3'b101,
    OP_RSI = 3'b110,
    OP_RCI = 3'b111
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_MRET  = 3'd3,
    ST_TRAP  = 3'd4,
    ST_RESP  = 3'd5
  } ctrl_state_e;

  // True for one of the four implemented machine-mode CSRs.
  function automatic logic csr_addr_known(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

  // funct3 values 000 and 100 are not Zicsr instructions.
  function automatic logic csr_op_legal(input logic [2:0] op);
    return (op != 3'b000) && (op != 3'b100);
  endfunction

  // Set/clear forms (funct3[1]==1) with a zero operand field never write.
  function automatic logic csr_write_suppressed(input logic [2:0] op,
                                                input logic [4:0] rs1_idx);
    return op[1] && (rs1_idx == 5'd0);
  endfunction

endpackage

// File: rtl/csr_wdata_alu.sv
// -----------------------------------------------------------------------------
// csr_wdata_alu
// Combinational merge of the old CSR value with the instruction operand.
// Ports:
//   i_op      : funct3 of the CSR instruction
//   i_old     : current CSR value
//   i_rs1_val : rs1 register value (register forms)
//   i_uimm    : 5-bit immediate (immediate forms), zero-extended
//   o_wdata   : value to write back to the CSR
// -----------------------------------------------------------------------------
module csr_wdata_alu
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [4:0]      i_uimm,
  output logic [XLEN-1:0] o_wdata
);

  logic [XLEN-1:0] w_src;

  // Operand select: funct3[2] marks the immediate forms.
  always_comb begin
    if (i_op[2]) begin
      w_src = {{(XLEN-5){1'b0}}, i_uimm};
    end else begin
      w_src = i_rs1_val;
    end
  end

  // Write/set/clear merge.
  always_comb begin
    case (i_op)
      OP_RW, OP_RWI: o_wdata = w_src;
      OP_RS, OP_RSI: o_wdata = i_old | w_src;
      OP_RC, OP_RCI: o_wdata = i_old & ~w_src;
      default:       o_wdata = i_old;
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// -----------------------------------------------------------------------------
// csr_access_ctrl
// Initiator side of the machine-mode CSR file port. Accepts Zicsr and MRET
// requests from execute, sequences read -> read-modify-write on the CSR port,
// raises illegal-instruction exceptions, pulses MRET and returns the old CSR
// value through a valid/ready response.
// Optional build macro: CSR_RO_CHECK_EN -- when defined, a non-suppressed write
// to an address with [11:10]==2'b11 (read-only space) traps.
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   req_*                  : request from execute (valid/ready)
//   resp_*                 : response to writeback (valid/ready)
//   csr_we_o/addr_o/wdata_o, csr_rdata_i : CSR file port
//   exception_o/pc_o/cause_o : exception-entry pulse and info
//   mret_o                 : MRET pulse
// All outputs are registered.
// -----------------------------------------------------------------------------
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN          = 32,
  parameter logic [XLEN-1:0] ILLEGAL_CAUSE = 32'd2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_mret_i,
  input  logic [2:0]      req_op_i,
  input  logic [11:0]     req_addr_i,
  input  logic [4:0]      req_rs1_idx_i,
  input  logic [XLEN-1:0] req_rs1_val_i,
  input  logic [XLEN-1:0] req_pc_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_illegal_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            exception_o,
  output logic [XLEN-1:0] exception_pc_o,
  output logic [XLEN-1:0] exception_cause_o,
  output logic            mret_o
);

  ctrl_state_e     r_state;
  logic [2:0]      r_op;
  logic [11:0]     r_addr;
  logic [4:0]      r_rs1_idx;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_old;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_illegal;
  logic            r_csr_we;
  logic [XLEN-1:0] r_csr_wdata;
  logic            r_exception;
  logic [XLEN-1:0] r_exc_pc;
  logic [XLEN-1:0] r_exc_cause;
  logic            r_mret;

  logic            w_ro_violation;
  logic            w_req_illegal;
  logic            w_suppressed;
  logic [XLEN-1:0] w_wdata;

`ifdef CSR_RO_CHECK_EN
  // Writes into the read-only CSR space trap unless the write is suppressed.
  assign w_ro_violation = (req_addr_i[11:10] == 2'b11) &&
                          !csr_write_suppressed(req_op_i, req_rs1_idx_i);
`else
  assign w_ro_violation = 1'b0;
`endif

  assign w_req_illegal = !csr_op_legal(req_op_i) || !csr_addr_known(req_addr_i) ||
                         w_ro_violation;
  assign w_suppressed  = csr_write_suppressed(r_op, r_rs1_idx);

  // Old value comes straight from the port in READ so the write lands next cycle.
  csr_wdata_alu #(.XLEN(XLEN)) u_wdata_alu (
    .i_op      (r_op),
    .i_old     (csr_rdata_i),
    .i_rs1_val (r_rs1_val),
    .i_uimm    (r_rs1_idx),
    .o_wdata   (w_wdata)
  );

  // Controller FSM; every output register is set on entry to the state that owns it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_op           <= 3'b000;
      r_addr         <= 12'h000;
      r_rs1_idx      <= 5'd0;
      r_rs1_val      <= {XLEN{1'b0}};
      r_old          <= {XLEN{1'b0}};
      r_req_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= {XLEN{1'b0}};
      r_resp_illegal <= 1'b0;
      r_csr_we       <= 1'b0;
      r_csr_wdata    <= {XLEN{1'b0}};
      r_exception    <= 1'b0;
      r_exc_pc       <= {XLEN{1'b0}};
      r_exc_cause    <= {XLEN{1'b0}};
      r_mret         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i && r_req_ready) begin
            r_op        <= req_op_i;
            r_addr      <= req_addr_i;
            r_rs1_idx   <= req_rs1_idx_i;
            r_rs1_val   <= req_rs1_val_i;
            r_req_ready <= 1'b0;
            if (req_mret_i) begin
              r_state <= ST_MRET;
              r_mret  <= 1'b1;
            end else if (w_req_illegal) begin
              // The faulting PC is captured directly into the exception output.
              r_state     <= ST_TRAP;
              r_exception <= 1'b1;
              r_exc_pc    <= req_pc_i;
              r_exc_cause <= ILLEGAL_CAUSE;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          r_old <= csr_rdata_i;
          if (w_suppressed) begin
            r_state        <= ST_RESP;
            r_resp_valid   <= 1'b1;
            r_resp_rdata   <= csr_rdata_i;
            r_resp_illegal <= 1'b0;
          end else begin
            r_state     <= ST_WRITE;
            r_csr_we    <= 1'b1;
            r_csr_wdata <= w_wdata;
          end
        end
        ST_WRITE: begin
          r_csr_we       <= 1'b0;
          r_state        <= ST_RESP;
          r_resp_valid   <= 1'b1;
          r_resp_rdata   <= r_old;
          r_resp_illegal <= 1'b0;
        end
        ST_MRET: begin
          r_mret         <= 1'b0;
          r_state        <= ST_RESP;
          r_resp_valid   <= 1'b1;
          r_resp_rdata   <= {XLEN{1'b0}};
          r_resp_illegal <= 1'b0;
        end
        ST_TRAP: begin
          r_exception    <= 1'b0;
          r_exc_pc       <= {XLEN{1'b0}};
          r_exc_cause    <= {XLEN{1'b0}};
          r_state        <= ST_RESP;
          r_resp_valid   <= 1'b1;
          r_resp_rdata   <= {XLEN{1'b0}};
          r_resp_illegal <= 1'b1;
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            r_state        <= ST_IDLE;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= {XLEN{1'b0}};
            r_resp_illegal <= 1'b0;
            r_req_ready    <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_csr_we     <= 1'b0;
          r_exception  <= 1'b0;
          r_mret       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o       = r_req_ready;
  assign resp_valid_o      = r_resp_valid;
  assign resp_rdata_o      = r_resp_rdata;
  assign resp_illegal_o    = r_resp_illegal;
  assign csr_we_o          = r_csr_we;
  assign csr_addr_o        = r_addr;
  assign csr_wdata_o       = r_csr_wdata;
  assign exception_o       = r_exception;
  assign exception_pc_o    = r_exc_pc;
  assign exception_cause_o = r_exc_cause;
  assign mret_o            = r_mret;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_csr_access_ctrl
// Directed plus randomized stimulus for csr_access_ctrl. Expected behaviour is
// derived from the instruction rules (legality, suppression, write merge and
// cycle latencies) and a four-entry array standing for the CSR contents.
// -----------------------------------------------------------------------------
module tb_csr_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_mret_i;
  logic [2:0]  req_op_i;
  logic [11:0] req_addr_i;
  logic [4:0]  req_rs1_idx_i;
  logic [31:0] req_rs1_val_i;
  logic [31:0] req_pc_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_illegal_o;
  logic        csr_we_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i;
  logic        exception_o;
  logic [31:0] exception_pc_o;
  logic [31:0] exception_cause_o;
  logic        mret_o;

  int n_cmp = 0;
  int n_bad = 0;

  // CSR file stand-in and the reference view of its contents
  logic [31:0] env_csr  [4];
  logic [31:0] init_val [4];
  logic [31:0] ref_csr  [4];
  logic        env_load;

  csr_access_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_mret_i(req_mret_i),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_rs1_idx_i(req_rs1_idx_i),
    .req_rs1_val_i(req_rs1_val_i), .req_pc_i(req_pc_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_illegal_o(resp_illegal_o),
    .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
    .csr_rdata_i(csr_rdata_i),
    .exception_o(exception_o), .exception_pc_o(exception_pc_o),
    .exception_cause_o(exception_cause_o), .mret_o(mret_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int csr_index(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return -1;
    endcase
  endfunction

  always_comb begin
    csr_rdata_i = 32'hDEAD_BEEF;
    if (csr_index(csr_addr_o) >= 0) csr_rdata_i = env_csr[2'(csr_index(csr_addr_o))];
  end

  always @(posedge clk_i) begin
    if (env_load) begin
      for (int i = 0; i < 4; i++) env_csr[i] <= init_val[i];
    end else if (csr_we_o && !rst_i && csr_index(csr_addr_o) >= 0) begin
      env_csr[2'(csr_index(csr_addr_o))] <= csr_wdata_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request with resp_ready_i held high; called #1 after a rising edge in IDLE.
  task automatic run_req(input logic mret, input logic [2:0] op, input logic [11:0] addr,
                         input logic [4:0] idx, input logic [31:0] val, input logic [31:0] pc);
    int ix, we_k, mret_k, exc_k, resp_k, we_cnt, mret_cnt, exc_cnt, stray;
    int e_we_k, e_mret_k, e_exc_k, e_resp_k;
    logic [31:0] we_data, we_addr, exc_pc, exc_cause, rdata, e_rdata, e_wdata, old, src;
    logic ill_obs, e_ill, supp, ro;
    ix = csr_index(addr);
    supp = (op == 3'd2 || op == 3'd3 || op == 3'd6 || op == 3'd7) && (idx == 5'd0);
    ro = 1'b0;
`ifdef CSR_RO_CHECK_EN
    ro = (addr[11:10] == 2'b11) && !supp;
`endif
    e_we_k = -1; e_mret_k = -1; e_exc_k = -1; e_resp_k = 2;
    e_rdata = 32'd0; e_ill = 1'b0; e_wdata = 32'd0;
    if (mret) begin
      e_mret_k = 1;
    end else if (op == 3'd0 || op == 3'd4 || ix < 0 || ro) begin
      e_exc_k = 1; e_ill = 1'b1;
    end else begin
      old = ref_csr[2'(ix)];
      e_rdata = old;
      if (!supp) begin
        src = (op >= 3'd5) ? {27'd0, idx} : val;
        if (op == 3'd1 || op == 3'd5)      e_wdata = src;
        else if (op == 3'd2 || op == 3'd6) e_wdata = old | src;
        else                               e_wdata = old & ~src;
        e_we_k = 2; e_resp_k = 3;
        ref_csr[2'(ix)] = e_wdata;
      end
    end

    chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_mret_i = mret; req_op_i = op; req_addr_i = addr;
    req_rs1_idx_i = idx; req_rs1_val_i = val; req_pc_i = pc; resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; req_mret_i = 1'($urandom); req_addr_i = 12'($urandom);
    we_k = -1; mret_k = -1; exc_k = -1; resp_k = -1;
    we_cnt = 0; mret_cnt = 0; exc_cnt = 0; stray = 0;
    we_data = 32'd0; we_addr = 32'd0; exc_pc = 32'd0; exc_cause = 32'd0;
    rdata = 32'd0; ill_obs = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (csr_we_o) begin
        we_cnt++;
        if (we_k < 0) begin we_k = k; we_data = csr_wdata_o; we_addr = {20'd0, csr_addr_o}; end
      end
      if (mret_o) begin mret_cnt++; if (mret_k < 0) mret_k = k; end
      if (exception_o) begin
        exc_cnt++;
        if (exc_k < 0) begin exc_k = k; exc_pc = exception_pc_o; exc_cause = exception_cause_o; end
      end else if (exception_pc_o != 32'd0 || exception_cause_o != 32'd0) begin
        stray++;
      end
      if (resp_valid_o) begin
        resp_k = k; rdata = resp_rdata_o; ill_obs = resp_illegal_o;
        break;
      end
      @(posedge clk_i); #1;
    end
    chk("resp_cycle", 32'(resp_k), 32'(e_resp_k));
    chk("resp_rdata", rdata, e_rdata);
    chk("resp_illegal", {31'd0, ill_obs}, {31'd0, e_ill});
    chk("we_cycle", 32'(we_k), 32'(e_we_k));
    chk("we_count", 32'(we_cnt), (e_we_k > 0) ? 32'd1 : 32'd0);
    chk("mret_cycle", 32'(mret_k), 32'(e_mret_k));
    chk("mret_count", 32'(mret_cnt), (e_mret_k > 0) ? 32'd1 : 32'd0);
    chk("exc_cycle", 32'(exc_k), 32'(e_exc_k));
    chk("exc_count", 32'(exc_cnt), (e_exc_k > 0) ? 32'd1 : 32'd0);
    chk("exc_info_outside_trap", 32'(stray), 32'd0);
    if (e_we_k > 0) begin
      chk("we_wdata", we_data, e_wdata);
      chk("we_addr", we_addr, {20'd0, addr});
    end
    if (e_exc_k > 0) begin
      chk("exc_pc", exc_pc, pc);
      chk("exc_cause", exc_cause, 32'd2);
    end
    @(posedge clk_i); #1;
    chk("resp_drop_after_hs", {31'd0, resp_valid_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] hold_val, hold_old, hold_rdata;
    int hold_k;
    rst_i = 1'b1; env_load = 1'b1;
    req_valid_i = 1'b0; req_mret_i = 1'b0; req_op_i = 3'd0; req_addr_i = 12'h000;
    req_rs1_idx_i = 5'd0; req_rs1_val_i = 32'd0; req_pc_i = 32'd0; resp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      init_val[i] = $urandom;
      ref_csr[i]  = init_val[i];
    end
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0; env_load = 1'b0;

    // Reset state
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_resp_rdata", resp_rdata_o, 32'd0);
    chk("rst_resp_illegal", {31'd0, resp_illegal_o}, 32'd0);
    chk("rst_csr_we", {31'd0, csr_we_o}, 32'd0);
    chk("rst_csr_addr", {20'd0, csr_addr_o}, 32'd0);
    chk("rst_csr_wdata", csr_wdata_o, 32'd0);
    chk("rst_exception", {31'd0, exception_o}, 32'd0);
    chk("rst_exc_pc", exception_pc_o, 32'd0);
    chk("rst_exc_cause", exception_cause_o, 32'd0);
    chk("rst_mret", {31'd0, mret_o}, 32'd0);

    // Directed cases
    run_req(1'b0, 3'd1, 12'h305, 5'd3, 32'h0000_0040, 32'h8000_0000);
    run_req(1'b0, 3'd1, 12'h305, 5'd3, 32'h0000_0100, 32'h8000_0004);
    run_req(1'b0, 3'd2, 12'h300, 5'd0, 32'hFFFF_FFFF, 32'h8000_0008);
    run_req(1'b0, 3'd1, 12'h300, 5'd7, 32'h0000_0008, 32'h8000_000C);
    run_req(1'b0, 3'd7, 12'h300, 5'd8, 32'h1234_5678, 32'h8000_000C);
    chk("rci_clears_bit", ref_csr[0], 32'h0000_0000);
    run_req(1'b0, 3'd1, 12'h7C0, 5'd1, 32'h0000_0001, 32'h8000_0010);
    run_req(1'b0, 3'd4, 12'h300, 5'd1, 32'h0000_0001, 32'h8000_0014);
    run_req(1'b1, 3'd1, 12'h341, 5'd1, 32'hAAAA_AAAA, 32'h8000_0018);
    run_req(1'b0, 3'd1, 12'hC00, 5'd1, 32'h0000_0005, 32'h8000_001C);
    run_req(1'b0, 3'd2, 12'hC00, 5'd0, 32'h0000_0005, 32'h8000_0020);
    run_req(1'b0, 3'd6, 12'h342, 5'd0, 32'h0000_0000, 32'h8000_0024);

    // Response back-pressure: held stable, new requests ignored
    hold_val = $urandom;
    hold_old = ref_csr[2];
    ref_csr[2] = hold_val;
    resp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_mret_i = 1'b0; req_op_i = 3'd1; req_addr_i = 12'h341;
    req_rs1_idx_i = 5'd9; req_rs1_val_i = hold_val; req_pc_i = 32'h8000_0100;
    @(posedge clk_i); #1;
    req_mret_i = 1'b1; req_op_i = 3'd0;
    hold_k = -1;
    for (int k = 1; k <= 6; k++) begin
      if (resp_valid_o) begin hold_k = k; break; end
      @(posedge clk_i); #1;
    end
    chk("hold_resp_cycle", 32'(hold_k), 32'd3);
    hold_rdata = resp_rdata_o;
    chk("hold_rdata", hold_rdata, hold_old);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      chk("hold_valid", {31'd0, resp_valid_o}, 32'd1);
      chk("hold_rdata_stable", resp_rdata_o, hold_old);
      chk("hold_req_ready", {31'd0, req_ready_o}, 32'd0);
      chk("hold_no_mret", {31'd0, mret_o}, 32'd0);
      chk("hold_no_exc", {31'd0, exception_o}, 32'd0);
      chk("hold_no_we", {31'd0, csr_we_o}, 32'd0);
    end
    req_valid_i = 1'b0; req_mret_i = 1'b0; resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("hold_release_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("hold_release_ready", {31'd0, req_ready_o}, 32'd1);

    // Reset while in WRITE: abandoned, no write, no response
    req_valid_i = 1'b1; req_mret_i = 1'b0; req_op_i = 3'd1; req_addr_i = 12'h300;
    req_rs1_idx_i = 5'd4; req_rs1_val_i = 32'hCAFE_F00D; req_pc_i = 32'h8000_0200;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rstw_in_write", {31'd0, csr_we_o}, 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("rstw_we", {31'd0, csr_we_o}, 32'd0);
    chk("rstw_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rstw_addr", {20'd0, csr_addr_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      chk("rstw_no_resp", {31'd0, resp_valid_o}, 32'd0);
    end

    // Randomized requests
    for (int t = 0; t < 60; t++) begin
      logic [11:0] a;
      logic [4:0]  ix5;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: a = 12'h300;
        2, 3: a = 12'h305;
        4, 5: a = 12'h341;
        6:    a = 12'h342;
        7:    a = 12'h7C0;
        8:    a = 12'hC00;
        default: a = 12'($urandom);
      endcase
      ix5 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_req(($urandom_range(0, 9) == 0), 3'($urandom), a, ix5, $urandom, $urandom);
    end

    // Read back every CSR without writing
    run_req(1'b0, 3'd2, 12'h300, 5'd0, 32'd0, 32'd0);
    run_req(1'b0, 3'd2, 12'h305, 5'd0, 32'd0, 32'd0);
    run_req(1'b0, 3'd6, 12'h341, 5'd0, 32'd0, 32'd0);
    run_req(1'b0, 3'd7, 12'h342, 5'd0, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
